// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared constants, FIFO entry type and range helper for the SRAM OBI arbiter.
package sram_arb_pkg;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;
  localparam logic [31:0] DEFAULT_END_ADDR = 32'h8000_C000;
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;
  typedef struct packed {
    logic [1:0] id;
    logic       err;
  } arb_entry_t;
  function automatic logic in_range(logic [31:0] a, logic [31:0] lo, logic [31:0] hi);
    return a >= lo && a < hi;
  endfunction
endpackage

// File: rtl/obi_id_fifo.sv
// obi_id_fifo: small synchronous FIFO of outstanding-transaction ids with simultaneous push/pop.
module obi_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] head_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q, rd_d, wr_d;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign head_o = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign rd_d = rd_q == AW'(DEPTH - 1) ? '0 : rd_q + 1'b1;
  assign wr_d = wr_q == AW'(DEPTH - 1) ? '0 : wr_q + 1'b1;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) mem_q[wr_q] <= wdata_i;
      if (do_push) wr_q <= wr_d;
      if (do_pop) rd_q <= rd_d;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/sram_obi_arbiter.sv
// sram_obi_arbiter: round-robin N-to-1 OBI arbiter in front of the SRAM data port,
// with in-order response routing and error responses for out-of-range addresses.
module sram_obi_arbiter #(
  parameter int          NUM_MASTERS     = 2,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] SRAM_BASE_ADDR  = sram_arb_pkg::DEFAULT_BASE_ADDR,
  parameter logic [31:0] SRAM_END_ADDR   = sram_arb_pkg::DEFAULT_END_ADDR
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_MASTERS-1:0]      m_req_i,
  output logic [NUM_MASTERS-1:0]      m_gnt_o,
  input  logic [NUM_MASTERS-1:0][31:0] m_addr_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS-1:0][3:0] m_be_i,
  input  logic [NUM_MASTERS-1:0][31:0] m_wdata_i,
  output logic [NUM_MASTERS-1:0]      m_rvalid_o,
  output logic [31:0]                 m_rdata_o,
  output logic                        m_err_o,
  output logic                        s_req_o,
  input  logic                        s_gnt_i,
  output logic [31:0]                 s_addr_o,
  output logic                        s_we_o,
  output logic [3:0]                  s_be_o,
  output logic [31:0]                 s_wdata_o,
  input  logic                        s_rvalid_i,
  input  logic [31:0]                 s_rdata_i,
  output logic                        illegal_access_o
);
  import sram_arb_pkg::*;
  localparam int IW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  logic [NUM_MASTERS-1:0] legal, elig;
  logic [IW-1:0] win, rr_q, rr_d;
  logic has_win, win_legal, accept, stall, pop, err_pend_q, ill_q;
  logic full, empty;
  logic [CW-1:0] count;
  arb_entry_t head, push_e;
  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      legal[i] = in_range(m_addr_i[i], SRAM_BASE_ADDR, SRAM_END_ADDR);
      elig[i] = m_req_i[i] && (legal[i] || count == '0);
    end
  end
  // Scan from the far end so the candidate nearest rr_q is the last one written.
  always_comb begin
    win = '0;
    has_win = 1'b0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (elig[IW'((int'(rr_q) + k) % NUM_MASTERS)]) begin
        win = IW'((int'(rr_q) + k) % NUM_MASTERS);
        has_win = 1'b1;
      end
    end
  end
  assign stall = full || err_pend_q;
  assign win_legal = legal[win];
  assign accept = has_win && !stall && (s_gnt_i || !win_legal);
  assign rr_d = win == IW'(NUM_MASTERS - 1) ? '0 : win + 1'b1;
  assign s_req_o = has_win && !stall && win_legal;
  assign s_addr_o = s_req_o ? m_addr_i[win] : '0;
  assign s_we_o = s_req_o ? m_we_i[win] : 1'b0;
  assign s_be_o = s_req_o ? m_be_i[win] : '0;
  assign s_wdata_o = s_req_o ? m_wdata_i[win] : '0;
  assign m_gnt_o = has_win && !stall ? NUM_MASTERS'(s_gnt_i || !win_legal) << win : '0;
  assign push_e = '{id: 2'(win), err: !win_legal};
  // An error entry is only ever pushed into an empty FIFO, so it reaches the head next cycle.
  assign pop = !empty && (head.err || s_rvalid_i);
  assign m_rvalid_o = pop ? NUM_MASTERS'(1) << head.id : '0;
  assign m_err_o = pop && head.err;
  assign m_rdata_o = !pop ? '0 : head.err ? ERR_RDATA : s_rdata_i;
  assign illegal_access_o = ill_q;
  obi_id_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH($bits(arb_entry_t))) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .wdata_i (push_e),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count),
    .head_o  (head)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= '0;
      err_pend_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      if (accept) rr_q <= rr_d;
      ill_q <= accept && !win_legal;
      err_pend_q <= (accept && !win_legal) || (err_pend_q && !(pop && head.err));
    end
  end
endmodule

// File: tb/tb_sram_obi_arbiter.sv
// tb_sram_obi_arbiter: vector table plus hand sequences against a simple SRAM model,
// with responses checked through an in-order scoreboard.
module tb_sram_obi_arbiter;
  logic clk_i, rst_i;
  logic [1:0] m_req_i, m_gnt_o, m_we_i, m_rvalid_o;
  logic [1:0][31:0] m_addr_i, m_wdata_i;
  logic [1:0][3:0] m_be_i;
  logic [31:0] m_rdata_o, s_addr_o, s_wdata_o, s_rdata_i;
  logic m_err_o, s_req_o, s_gnt_i, s_we_o, s_rvalid_i, illegal_access_o;
  logic [3:0] s_be_o;

  typedef struct {
    logic [1:0]  req;
    logic [31:0] a0, a1;
    logic [1:0]  we, gnt;
    logic        sreq, ill;
  } vec_t;
  typedef struct {
    int          id;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  resp_t sb[$];
  logic [31:0] pend[$];
  vec_t tbl[$];
  int n_checks = 0, n_fail = 0;
  logic hold = 1'b0, stray = 1'b0, rv_q = 1'b0, acc = 1'b0, cons = 1'b0;
  logic [31:0] rd_q = '0, acc_addr = '0;

  sram_obi_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i), .m_req_i(m_req_i), .m_gnt_o(m_gnt_o),
    .m_addr_i(m_addr_i), .m_we_i(m_we_i), .m_be_i(m_be_i), .m_wdata_i(m_wdata_i),
    .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
    .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
    .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i),
    .s_rdata_i(s_rdata_i), .illegal_access_o(illegal_access_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] sram_data(logic [31:0] a);
    return a == 32'h8000_0010 ? 32'h1234_5678 : a ^ 32'h1357_9BDF;
  endfunction
  function automatic logic legal(logic [31:0] a);
    return a >= 32'h8000_0000 && a < 32'h8000_C000;
  endfunction
  function automatic vec_t mk(logic [1:0] req, logic [31:0] a0, logic [31:0] a1,
                              logic [1:0] we, logic [1:0] gnt, logic sreq, logic ill);
    vec_t v;
    v.req = req; v.a0 = a0; v.a1 = a1; v.we = we; v.gnt = gnt; v.sreq = sreq; v.ill = ill;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM wrapper model: grant equals request, read data one cycle later unless held back.
  assign s_gnt_i = s_req_o;
  assign s_rvalid_i = rv_q | stray;
  assign s_rdata_i = stray ? 32'h5555_AAAA : rd_q;

  always @(negedge clk_i) begin
    resp_t e;
    acc = s_req_o && s_gnt_i;
    acc_addr = s_addr_o;
    cons = rv_q;
    if (!rst_i) begin
      if (m_rvalid_o != 2'b00) begin
        if (sb.size() == 0) chk("unexpected_rvalid", 32'(m_rvalid_o), 32'd0);
        else begin
          e = sb.pop_front();
          chk("rvalid_route", 32'(m_rvalid_o), 32'd1 << e.id);
          chk("resp_err", 32'(m_err_o), 32'(e.err));
          chk("resp_rdata", m_rdata_o, e.rdata);
        end
      end else chk("idle_rdata", {m_rdata_o[31:1], m_rdata_o[0] | m_err_o}, 32'd0);
    end
  end

  always @(posedge clk_i) begin
    if (rst_i) begin
      pend.delete();
      rv_q <= 1'b0;
    end else begin
      if (cons && pend.size() != 0) void'(pend.pop_front());
      if (acc) pend.push_back(sram_data(acc_addr));
      rv_q <= !hold && pend.size() != 0;
      rd_q <= pend.size() != 0 ? pend[0] : 32'd0;
    end
  end

  task automatic apply(vec_t v);
    logic sel;
    resp_t r;
    m_req_i = v.req;
    m_addr_i[0] = v.a0;
    m_addr_i[1] = v.a1;
    m_we_i = v.we;
    m_be_i[0] = 4'hF;
    m_be_i[1] = 4'h5;
    m_wdata_i[0] = ~v.a0;
    m_wdata_i[1] = ~v.a1;
    #3;
    chk("gnt", 32'(m_gnt_o), 32'(v.gnt));
    chk("s_req", 32'(s_req_o), 32'(v.sreq));
    chk("illegal_pulse", 32'(illegal_access_o), 32'(v.ill));
    if (v.sreq) begin
      sel = v.gnt[1];
      chk("s_addr", s_addr_o, sel ? v.a1 : v.a0);
      chk("s_we", 32'(s_we_o), 32'(v.we[sel]));
      chk("s_be", 32'(s_be_o), sel ? 32'h5 : 32'hF);
      chk("s_wdata", s_wdata_o, sel ? ~v.a1 : ~v.a0);
    end
    for (int i = 0; i < 2; i++) begin
      if (v.gnt[i]) begin
        r.id = i;
        r.err = !legal(i == 1 ? v.a1 : v.a0);
        r.rdata = r.err ? 32'hDEAD_BEEF : sram_data(i == 1 ? v.a1 : v.a0);
        sb.push_back(r);
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    vec_t idle, busy;
    idle = mk(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0);
    rst_i = 1'b1;
    m_req_i = '0; m_addr_i = '0; m_we_i = '0; m_be_i = '0; m_wdata_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #3;
    chk("rst_gnt", 32'(m_gnt_o), 32'd0);
    chk("rst_s_req", 32'(s_req_o), 32'd0);
    chk("rst_rvalid", 32'(m_rvalid_o), 32'd0);
    chk("rst_err", 32'(m_err_o), 32'd0);
    chk("rst_illegal", 32'(illegal_access_o), 32'd0);
    chk("rst_s_addr", s_addr_o, 32'd0);
    @(posedge clk_i);
    #1;
    // single read, alternation, illegal accesses, and range boundaries
    tbl.push_back(mk(2'b01, 32'h8000_0010, 32'h0,         2'b00, 2'b01, 1, 0));
    tbl.push_back(idle);
    tbl.push_back(mk(2'b11, 32'h8000_0020, 32'h8000_0024, 2'b00, 2'b10, 1, 0));
    tbl.push_back(mk(2'b11, 32'h8000_0028, 32'h8000_002C, 2'b01, 2'b01, 1, 0));
    tbl.push_back(mk(2'b11, 32'h8000_0030, 32'h8000_0034, 2'b10, 2'b10, 1, 0));
    tbl.push_back(mk(2'b11, 32'h8000_0038, 32'h8000_003C, 2'b00, 2'b01, 1, 0));
    tbl.push_back(idle);
    tbl.push_back(mk(2'b10, 32'h0,         32'h0000_0100, 2'b00, 2'b10, 0, 0));
    tbl.push_back(mk(2'b01, 32'h8000_0040, 32'h0,         2'b00, 2'b00, 0, 1));
    tbl.push_back(mk(2'b01, 32'h8000_0040, 32'h0,         2'b00, 2'b01, 1, 0));
    tbl.push_back(idle);
    tbl.push_back(mk(2'b01, 32'h8000_0044, 32'h0,         2'b00, 2'b01, 1, 0));
    tbl.push_back(mk(2'b10, 32'h0,         32'h0000_0200, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(2'b10, 32'h0,         32'h0000_0200, 2'b00, 2'b10, 0, 0));
    tbl.push_back(mk(2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 0, 1));
    tbl.push_back(mk(2'b01, 32'h8000_0000, 32'h0,         2'b00, 2'b01, 1, 0));
    tbl.push_back(idle);
    tbl.push_back(mk(2'b10, 32'h0,         32'h8000_BFFC, 2'b00, 2'b10, 1, 0));
    tbl.push_back(mk(2'b01, 32'h8000_C000, 32'h0,         2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(2'b01, 32'h8000_C000, 32'h0,         2'b00, 2'b01, 0, 0));
    tbl.push_back(mk(2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 0, 1));
    tbl.push_back(mk(2'b10, 32'h0,         32'h7FFF_FFFC, 2'b00, 2'b10, 0, 0));
    tbl.push_back(mk(2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 0, 1));
    foreach (tbl[i]) apply(tbl[i]);
    // slow slave: two grants fill the FIFO, then nothing until a response drains it
    hold = 1'b1;
    busy = mk(2'b11, 32'h8000_0108, 32'h8000_010C, 2'b00, 2'b00, 0, 0);
    apply(mk(2'b11, 32'h8000_0100, 32'h8000_0104, 2'b00, 2'b01, 1, 0));
    apply(mk(2'b11, 32'h8000_0108, 32'h8000_010C, 2'b00, 2'b10, 1, 0));
    apply(busy);
    apply(busy);
    hold = 1'b0;
    apply(busy);
    apply(busy);
    apply(mk(2'b11, 32'h8000_0110, 32'h8000_0114, 2'b00, 2'b01, 1, 0));
    apply(idle);
    apply(idle);
    // reset with two outstanding, stray rvalid, then arbitration restarts at master 0
    hold = 1'b1;
    apply(mk(2'b10, 32'h0, 32'h8000_0200, 2'b00, 2'b10, 1, 0));
    apply(mk(2'b01, 32'h8000_0204, 32'h0, 2'b00, 2'b01, 1, 0));
    rst_i = 1'b1;
    sb.delete();
    apply(idle);
    rst_i = 1'b0;
    hold = 1'b0;
    stray = 1'b1;
    apply(idle);
    stray = 1'b0;
    apply(mk(2'b11, 32'h8000_0300, 32'h8000_0304, 2'b00, 2'b01, 1, 0));
    apply(idle);
    apply(idle);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
